// File: rtl/azadi_boot_pkg.sv
// Shared types and constants for the Azadi boot loader.
//   boot_state_e     : top-level load sequencer states
//   rx_state_e       : 8N1 receiver states
//   MIN_CLKS_PER_BIT : floor applied to the programmed UART bit period
//   BYTE_CNT_W       : width of the byte-within-word counter
package azadi_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StDone,
        StErr
    } boot_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    localparam int unsigned MIN_CLKS_PER_BIT = 4;
    localparam int unsigned BYTE_CNT_W       = 2;

    // Bit periods below the floor cannot place a mid-bit sample sensibly.
    function automatic logic [15:0] eff_clks_per_bit(input logic [15:0] cpb);
        return (cpb < 16'(MIN_CLKS_PER_BIT)) ? 16'(MIN_CLKS_PER_BIT) : cpb;
    endfunction

endpackage

// File: rtl/azadi_boot_uart_rx.sv
// 8N1 UART receiver, LSB first, always running.
// Ports:
//   clk_i, rst_ni    : clock, async active-low reset
//   clks_per_bit_i   : bit period in clk_i cycles (values < 4 treated as 4)
//   rx_i             : serial line, idle high, asynchronous to clk_i
//   rx_valid_o       : 1-cycle pulse, rx_byte_o holds a byte with a good stop bit
//   rx_byte_o        : last received byte
//   rx_ferr_o        : 1-cycle pulse on a 0 stop bit
module azadi_boot_uart_rx
    import azadi_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] clks_per_bit_i,
    input  logic        rx_i,
    output logic        rx_valid_o,
    output logic [7:0]  rx_byte_o,
    output logic        rx_ferr_o
);

    rx_state_e   state_q, state_d;
    logic [1:0]  rx_sync_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    logic [15:0] cpb;
    logic [15:0] half;
    logic        rx;

    assign cpb  = eff_clks_per_bit(clks_per_bit_i);
    assign half = cpb >> 1;
    assign rx   = rx_sync_q[1];

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RxIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; the line resets to idle-high so no false start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_q <= 2'b11;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_i};
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d = RxStart;
                end
            end
            RxStart: begin
                // Confirm the start bit at mid-bit to reject glitches.
                if (cnt_q == half - 16'd1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (cnt_q == cpb - 16'd1) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = RxStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (cnt_q == cpb - 16'd1) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                    if (rx) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        rx_valid_o = valid_q;
        rx_byte_o  = byte_q;
        rx_ferr_o  = ferr_q;
    end

endmodule

// File: rtl/azadi_boot_loader.sv
// Boot path sequencer: a debounced PROG press holds the core in reset, a program
// image (4-byte little-endian word count, then the words) is received over UART
// and written to instruction memory, and the core reset is released afterwards.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   prog_i                 : raw PROG button (asynchronous)
//   clks_per_bit_i         : UART bit period in clk_i cycles
//   uart_rx_i              : UART receive line
//   mem_req_o/we/be/addr/wdata, mem_gnt_i : instruction memory write port
//   core_rst_no            : active-low core reset
//   boot_led_o             : loading indicator
//   busy_o                 : load in progress (not IDLE, not ERR)
//   err_o                  : sticky load error
module azadi_boot_loader
    import azadi_boot_pkg::*;
#(
    parameter int unsigned AW              = 12,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int unsigned MAX_WORDS       = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          prog_i,
    input  logic [15:0]   clks_per_bit_i,
    input  logic          uart_rx_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_gnt_i,
    output logic          core_rst_no,
    output logic          boot_led_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam int unsigned WCW = $clog2(MAX_WORDS + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

    // ---------------------------------------------------------------------------------------
    // PROG synchronizer and debounce
    // ---------------------------------------------------------------------------------------
    logic [1:0]     prog_sync_q;
    logic           db_cand_q, db_cand_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           stable_q, stable_d;
    logic           stable_dly_q;
    logic           press;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prog_sync_q  <= '0;
            db_cand_q    <= 1'b0;
            db_cnt_q     <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            prog_sync_q  <= {prog_sync_q[0], prog_i};
            db_cand_q    <= db_cand_d;
            db_cnt_q     <= db_cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    always_comb begin
        db_cand_d = db_cand_q;
        db_cnt_d  = db_cnt_q;
        stable_d  = stable_q;
        if (prog_sync_q[1] != db_cand_q) begin
            db_cand_d = prog_sync_q[1];
            db_cnt_d  = '0;
        end else if (db_cnt_q != DBW'(DEBOUNCE_CYCLES)) begin
            db_cnt_d = db_cnt_q + DBW'(1);
        end else begin
            stable_d = db_cand_q;
        end
    end

    assign press = stable_q & ~stable_dly_q;

    // ---------------------------------------------------------------------------------------
    // UART receiver
    // ---------------------------------------------------------------------------------------
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    azadi_boot_uart_rx u_uart_rx (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clks_per_bit_i (clks_per_bit_i),
        .rx_i           (uart_rx_i),
        .rx_valid_o     (rx_valid),
        .rx_byte_o      (rx_byte),
        .rx_ferr_o      (rx_ferr)
    );

    // ---------------------------------------------------------------------------------------
    // Load sequencer
    // ---------------------------------------------------------------------------------------
    boot_state_e           state_q, state_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]        word_cnt_q, word_cnt_d;
    logic [WCW-1:0]        len_q, len_d;
    logic [31:0]           shift_q, shift_d;
    logic [TW-1:0]         timeout_q, timeout_d;
    logic                  req_q, req_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic [31:0] rx_word;
    logic        timeout_hit;
    logic        gnt_done;

    assign rx_word     = {rx_byte, shift_q[31:8]};
    assign timeout_hit = (timeout_q == TW'(TIMEOUT_CYCLES - 1));
    assign gnt_done    = req_q & mem_gnt_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            timeout_q  <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            timeout_q  <= timeout_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state logic. A press is evaluated before any byte so it always wins.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        timeout_d  = timeout_q;
        req_d      = gnt_done ? 1'b0 : req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle, StErr: begin
                if (press) begin
                    state_d    = StLen;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                    timeout_d  = '0;
                end
            end
            StLen, StData: begin
                timeout_d = (rx_valid || rx_ferr) ? '0 : timeout_q + TW'(1);
                if (press) begin
                    state_d    = StLen;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                    timeout_d  = '0;
                    req_d      = 1'b0;
                end else if (rx_ferr || (!rx_valid && timeout_hit)) begin
                    state_d = StErr;
                    req_d   = 1'b0;
                end else if (state_q == StLen) begin
                    if (rx_valid) begin
                        shift_d    = rx_word;
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        if (byte_cnt_q == '1) begin
                            len_d = WCW'(rx_word);
                            if (rx_word == 32'd0) begin
                                state_d = StDone;
                            end else if (rx_word > 32'(MAX_WORDS)) begin
                                state_d = StErr;
                            end else begin
                                state_d = StData;
                            end
                        end
                    end
                end else begin
                    // Only one write is ever outstanding, so the grant seen once every
                    // word has been issued belongs to the last word.
                    if (gnt_done && (word_cnt_q == len_q)) begin
                        state_d = StDone;
                    end else if (rx_valid && (word_cnt_q != len_q)) begin
                        shift_d    = rx_word;
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        if (byte_cnt_q == '1) begin
                            if (req_q && !mem_gnt_i) begin
                                state_d = StErr;
                                req_d   = 1'b0;
                            end else begin
                                req_d      = 1'b1;
                                wdata_d    = rx_word;
                                addr_d     = AW'(BASE_ADDR) + AW'({word_cnt_q, 2'b00});
                                word_cnt_d = word_cnt_q + WCW'(1);
                            end
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        mem_req_o   = req_q;
        mem_we_o    = req_q;
        mem_be_o    = req_q ? 4'hF : 4'h0;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        core_rst_no = (state_q == StIdle);
        boot_led_o  = (state_q == StLen) || (state_q == StData) || (state_q == StDone);
        busy_o      = (state_q != StIdle) && (state_q != StErr);
        err_o       = (state_q == StErr);
    end

endmodule

// File: tb/tb_azadi_boot_loader.sv
module tb_azadi_boot_loader;

    localparam int unsigned AW   = 12;
    localparam int unsigned BASE = 0;
    localparam int unsigned MAXW = 1024;
    localparam int unsigned DEB  = 1000;
    localparam int unsigned TMO  = 3000;
    localparam int unsigned CPB  = 16;

    logic          clk;
    logic          rst_n;
    logic          prog;
    logic [15:0]   cpb;
    logic          uart_rx;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          core_rst_n;
    logic          boot_led;
    logic          busy;
    logic          err;

    azadi_boot_loader #(
        .AW              (AW),
        .BASE_ADDR       (BASE),
        .MAX_WORDS       (MAXW),
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .prog_i         (prog),
        .clks_per_bit_i (cpb),
        .uart_rx_i      (uart_rx),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_gnt_i      (mem_gnt),
        .core_rst_no    (core_rst_n),
        .boot_led_o     (boot_led),
        .busy_o         (busy),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_writes = 0;
    int n_release = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard of expected memory writes.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Grant responder: grants 3 cycles after req rises, checks the write at grant.
    bit            gnt_en = 1'b1;
    int            gnt_dly = 0;
    logic          prev_req = 1'b0;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;

    initial begin
        mem_gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_gnt) begin
                mem_gnt = 1'b0;
                gnt_dly = 0;
                check("req_drop_after_gnt", {31'd0, mem_req}, 32'd0);
            end else if (mem_req && gnt_en) begin
                if (!prev_req) begin
                    req_addr = mem_addr;
                    req_data = mem_wdata;
                    gnt_dly  = 0;
                end
                if (gnt_dly == 3) begin
                    mem_gnt = 1'b1;
                    n_writes++;
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_write: addr %h data %h, expected no write",
                                 mem_addr, mem_wdata);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_addr", {20'd0, mem_addr}, e.addr);
                        check("wr_data", mem_wdata, e.data);
                        check("wr_be", {28'd0, mem_be}, 32'hF);
                        check("wr_we", {31'd0, mem_we}, 32'd1);
                        check("wr_addr_stable", {20'd0, mem_addr}, {20'd0, req_addr});
                        check("wr_data_stable", mem_wdata, req_data);
                    end
                end else begin
                    gnt_dly++;
                end
            end else begin
                gnt_dly = 0;
            end
            prev_req = mem_req;
        end
    end

    // Core reset release must follow exactly one DONE cycle.
    logic pb = 1'b0;
    logic pr = 1'b1;
    logic pl = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !pr && core_rst_n) begin
                n_release++;
                check("busy_in_done_cycle", {31'd0, pb}, 32'd1);
                check("led_high_in_done_cycle", {31'd0, pl}, 32'd1);
                check("led_falls_with_release", {31'd0, boot_led}, 32'd0);
            end
            pb = busy;
            pr = core_rst_n;
            pl = boot_led;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic press();
        prog = 1'b1;
        repeat (DEB + 50) @(negedge clk);
        prog = 1'b0;
        repeat (DEB + 50) @(negedge clk);
    endtask

    task automatic wait_not_busy(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_total++;
            $display("FAIL idle_wait: busy_o still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    typedef struct {
        string       name;
        int          nbytes;
        logic [7:0]  bytes [12];
        int          nwr;
        logic [31:0] waddr [2];
        logic [31:0] wdata [2];
        logic        exp_err;
        logic        exp_rst;
    } vec_t;

    vec_t tbl[4];

    logic seen_busy;
    logic seen_rst;
    int   rel0;
    int   wr0;

    initial begin
        tbl[0].name = "two_words";
        tbl[0].nbytes = 12;
        tbl[0].bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                         8'h67, 8'h45, 8'h23, 8'h01};
        tbl[0].nwr = 2;
        tbl[0].waddr = '{32'd0, 32'd4};
        tbl[0].wdata = '{32'hDEADBEEF, 32'h01234567};
        tbl[0].exp_err = 1'b0;
        tbl[0].exp_rst = 1'b1;

        tbl[1].name = "zero_len";
        tbl[1].nbytes = 4;
        tbl[1].bytes = '{default: 8'h00};
        tbl[1].nwr = 0;
        tbl[1].waddr = '{32'd0, 32'd0};
        tbl[1].wdata = '{32'd0, 32'd0};
        tbl[1].exp_err = 1'b0;
        tbl[1].exp_rst = 1'b1;

        tbl[2].name = "too_long";
        tbl[2].nbytes = 4;
        tbl[2].bytes = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].nwr = 0;
        tbl[2].waddr = '{32'd0, 32'd0};
        tbl[2].wdata = '{32'd0, 32'd0};
        tbl[2].exp_err = 1'b1;
        tbl[2].exp_rst = 1'b0;

        tbl[3].name = "one_word_from_err";
        tbl[3].nbytes = 8;
        tbl[3].bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                         8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3].nwr = 1;
        tbl[3].waddr = '{32'd0, 32'd0};
        tbl[3].wdata = '{32'h44332211, 32'd0};
        tbl[3].exp_err = 1'b0;
        tbl[3].exp_rst = 1'b1;

        rst_n   = 1'b0;
        prog    = 1'b0;
        uart_rx = 1'b1;
        cpb     = 16'(CPB);
        repeat (3) @(negedge clk);

        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        check("rst_boot_led", {31'd0, boot_led}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 999-cycle pulse is one short of a press.
        seen_busy = 1'b0;
        seen_rst  = 1'b0;
        prog = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            if (i == 999) prog = 1'b0;
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
            if (!core_rst_n) seen_rst = 1'b1;
        end
        check("short_press_busy", {31'd0, seen_busy}, 32'd0);
        check("short_press_core_rst", {31'd0, seen_rst}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            press();
            check({tbl[v].name, "_busy_after_press"}, {31'd0, busy}, 32'd1);
            check({tbl[v].name, "_core_rst_held"}, {31'd0, core_rst_n}, 32'd0);
            check({tbl[v].name, "_led_on"}, {31'd0, boot_led}, 32'd1);
            check({tbl[v].name, "_err_cleared"}, {31'd0, err}, 32'd0);
            rel0 = n_release;
            wr0  = n_writes;
            for (int w = 0; w < tbl[v].nwr; w++) push_wr(tbl[v].waddr[w], tbl[v].wdata[w]);
            for (int b = 0; b < tbl[v].nbytes; b++) send_byte(tbl[v].bytes[b], 1'b1);
            wait_not_busy(500);
            repeat (3) @(negedge clk);
            check({tbl[v].name, "_err"}, {31'd0, err}, {31'd0, tbl[v].exp_err});
            check({tbl[v].name, "_core_rst"}, {31'd0, core_rst_n}, {31'd0, tbl[v].exp_rst});
            check({tbl[v].name, "_led_off"}, {31'd0, boot_led}, 32'd0);
            check({tbl[v].name, "_writes"}, n_writes - wr0, tbl[v].nwr);
            check({tbl[v].name, "_sb_empty"}, exp_q.size(), 32'd0);
            check({tbl[v].name, "_releases"}, n_release - rel0, {31'd0, tbl[v].exp_rst});
        end

        // Overrun: no grant while a second word completes.
        gnt_en = 1'b0;
        press();
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        check("ovr_req_pending", {31'd0, mem_req}, 32'd1);
        check("ovr_wdata", mem_wdata, 32'h04030201);
        check("ovr_addr", {20'd0, mem_addr}, 32'd0);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h08, 1'b1);
        check("ovr_err", {31'd0, err}, 32'd1);
        check("ovr_req_dropped", {31'd0, mem_req}, 32'd0);
        check("ovr_core_rst", {31'd0, core_rst_n}, 32'd0);
        check("ovr_led_off", {31'd0, boot_led}, 32'd0);
        gnt_en = 1'b1;

        // Framing error.
        press();
        check("ferr_busy_before", {31'd0, busy}, 32'd1);
        send_byte(8'h55, 1'b0);
        check("ferr_err", {31'd0, err}, 32'd1);
        check("ferr_busy", {31'd0, busy}, 32'd0);

        // Inter-byte timeout.
        press();
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TMO - 200) @(negedge clk);
        check("tmo_not_yet", {31'd0, err}, 32'd0);
        repeat (300) @(negedge clk);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_core_rst", {31'd0, core_rst_n}, 32'd0);

        // Press mid-DATA restarts from BASE_ADDR.
        press();
        push_wr(32'd0, 32'h0D0C0B0A);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h0C, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'hEE, 1'b1);
        send_byte(8'hFF, 1'b1);
        press();
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_err", {31'd0, err}, 32'd0);
        check("restart_req", {31'd0, mem_req}, 32'd0);
        push_wr(32'd0, 32'hDDCCBBAA);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        wait_not_busy(500);
        check("restart_done_core_rst", {31'd0, core_rst_n}, 32'd1);
        check("restart_sb_empty", exp_q.size(), 32'd0);

        // Asynchronous reset mid-load.
        press();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_core_rst", {31'd0, core_rst_n}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_led", {31'd0, boot_led}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        check("arst_req", {31'd0, mem_req}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_after_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
